load_sequencer: RTL and testbench
=================================

LOAD_SEQUENCER -- requirements
Module: load_sequencer

Interface
REQ-001 Parameter W_BYTES, default 54, is the number of weight bytes per frame (3x3x3x2).
REQ-002 Parameter D_BYTES, default 64, is the number of feature bytes per frame (8x8x1).
REQ-003 Parameter SETTLE_CYC, default 2, is the number of cycles waited after the last RAM write before the result is sampled.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a frame; sampled only in IDLE.
REQ-007 s_valid  in  1  upstream byte valid.
REQ-008 s_data  in  8  upstream byte.
REQ-009 s_ready  out  1  byte accepted when s_valid and s_ready are both high.
REQ-010 mode  out  1  RAM select to the inference core: 1 = weight, 0 = data.
REQ-011 ram_en  out  1  RAM write strobe to the inference core.
REQ-012 din  out  8  RAM write byte to the inference core.
REQ-013 res_data  in  8  core result byte (combinational).
REQ-014 res_flag  in  1  core result-nonzero flag.
REQ-015 m_valid  out  1  result valid.
REQ-016 m_data  out  8  captured result.
REQ-017 m_flag  out  1  captured flag.
REQ-018 m_ready  in  1  result consumer ready.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 frame_done  out  1  one-cycle pulse on result handoff.

Function
REQ-021 FSM states and transitions:
  - IDLE: to LOAD_W on start.
  - LOAD_W: to LOAD_D when W_BYTES bytes are accepted.
  - LOAD_D: to SETTLE when D_BYTES bytes are accepted.
  - SETTLE: to OUT after SETTLE_CYC cycles.
  - OUT: to IDLE on m_valid && m_ready.
REQ-022 s_ready is high in LOAD_W and LOAD_D and low in all other states; it is a registered or state-decoded output with no combinational path from s_valid.
REQ-023 Each accepted byte drives ram_en=1 and din=s_data on the next cycle, with mode=1 for bytes from LOAD_W and mode=0 for bytes from LOAD_D; ram_en is 0 otherwise.
REQ-024 A 7-bit byte counter clears on entry to LOAD_W and LOAD_D and increments per accepted byte; the state changes in the cycle in which the byte with count = limit-1 is accepted.
REQ-025 A gap in s_valid stalls loading indefinitely; no timeout.
REQ-026 SETTLE starts counting in the cycle after the final ram_en pulse; res_data and res_flag are captured into m_data and m_flag on the cycle the count expires, and m_valid rises on the following cycle.
REQ-027 m_data, m_flag and m_valid hold stable while m_valid && !m_ready.
REQ-028 frame_done pulses in the cycle after the handshake, together with the return to IDLE.
REQ-029 start outside IDLE is ignored, including start coincident with the OUT handshake.
REQ-030 Minimum frame latency with s_valid held high and m_ready high: W_BYTES + D_BYTES + SETTLE_CYC + 3 cycles from start to frame_done.

Reset
REQ-031 On rst: state = IDLE; counters = 0; s_ready, ram_en, mode, din, m_valid, m_data, m_flag, busy and frame_done = 0.
REQ-032 rst asserted mid-frame aborts the frame with no further ram_en pulses; the system resets the inference core's address counters from the same rst.

Configuration
REQ-033 LOAD_SEQ_KEEPW_EN defined: an extra input keep_w (1 bit) is present; start with keep_w=1 goes IDLE->LOAD_D, skipping weight load and reusing the weights already in the core.
REQ-034 LOAD_SEQ_KEEPW_EN undefined: keep_w is absent and every frame loads weights.

Structure
REQ-035 The shared package holds the state enum (IDLE, LOAD_W, LOAD_D, SETTLE, OUT), the MODE_WEIGHT=1 and MODE_DATA=0 constants, and the default byte counts 54 and 64.
REQ-036 A single sub-module, seq_out_reg, holds the result holding register with valid/ready; everything else is flat.

Verification
REQ-037 rst, start, 118 bytes streamed back-to-back -> 54 ram_en pulses with mode=1, then 64 with mode=0, din matching the stream in order, and frame_done at cycle 123.
REQ-038 s_valid toggled 1-0-1 every cycle -> the ram_en count is still 54/64, and no byte is dropped or duplicated.
REQ-039 res_data=8'hA5, res_flag=1, m_ready held 0 for 10 cycles -> m_valid=1, m_data=A5 and m_flag=1 stay stable; frame_done pulses one cycle after m_ready rises.
REQ-040 rst asserted after 30 weight bytes -> the next cycle shows ram_en=0, s_ready=0, busy=0; a new start loads 54 weight bytes from the beginning.
REQ-041 start pulsed during LOAD_D and during OUT -> no state change and no second frame.
REQ-042 With LOAD_SEQ_KEEPW_EN, start with keep_w=1 -> no mode=1 writes, exactly 64 mode=0 writes, and frame_done at cycle 69.

Source files
------------

// File: rtl/load_sequencer_pkg.sv
// Shared types and constants for the load sequencer.
package load_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LOAD_D = 3'd2,
        SETTLE = 3'd3,
        OUT    = 3'd4
    } state_t;

    localparam logic MODE_WEIGHT = 1'b1;
    localparam logic MODE_DATA   = 1'b0;

    localparam int DEF_W_BYTES    = 54;   // 3x3x3x2 weights
    localparam int DEF_D_BYTES    = 64;   // 8x8x1 features
    localparam int DEF_SETTLE_CYC = 2;

endpackage

// File: rtl/seq_out_reg.sv
// Result holding register with valid/ready handshake.
module seq_out_reg (
    input  logic       clk,
    input  logic       rst,
    input  logic       capture,
    input  logic [7:0] cap_data,
    input  logic       cap_flag,
    input  logic       m_ready,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic       m_flag
);

    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;
    logic       flag_q, flag_d;

    // Load on capture, drop valid on handshake, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        flag_d  = flag_q;
        if (capture) begin
            valid_d = 1'b1;
            data_d  = cap_data;
            flag_d  = cap_flag;
        end else if (valid_q && m_ready) begin
            valid_d = 1'b0;
        end
    end

    // Holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            flag_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
        end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_flag  = flag_q;

endmodule

// File: rtl/load_sequencer.sv
// Load sequencer: streams weight then feature bytes into the inference core,
// waits for the core to settle and hands the result off downstream.
// Optional macro LOAD_SEQ_KEEPW_EN adds input keep_w to skip the weight load.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | accepting weight bytes (mode = weight)
// LOAD_D | accepting feature bytes (mode = data)
// SETTLE | core settling after the final write
// OUT    | result held until consumer takes it
module load_sequencer
    import load_sequencer_pkg::*;
#(
    parameter int W_BYTES    = DEF_W_BYTES,
    parameter int D_BYTES    = DEF_D_BYTES,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef LOAD_SEQ_KEEPW_EN
    input  logic       keep_w,
`endif
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       mode,
    output logic       ram_en,
    output logic [7:0] din,
    input  logic [7:0] res_data,
    input  logic       res_flag,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic       m_flag,
    input  logic       m_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [6:0] W_LAST      = 7'(W_BYTES - 1);
    localparam logic [6:0] D_LAST      = 7'(D_BYTES - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC);

    state_t     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [7:0] settle_q, settle_d;
    logic       ram_en_q, ram_en_d;
    logic       mode_q, mode_d;
    logic [7:0] din_q, din_d;
    logic       frame_done_q, frame_done_d;
    logic       accept, capture, handshake, skip_w;

`ifdef LOAD_SEQ_KEEPW_EN
    assign skip_w = keep_w;
`else
    assign skip_w = 1'b0;
`endif

    assign s_ready   = (state_q == LOAD_W) || (state_q == LOAD_D);
    assign accept    = s_valid && s_ready;
    assign handshake = m_valid && m_ready;

    // Next-state, byte counter, settle timer and RAM write pipeline.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        settle_d     = settle_q;
        capture      = 1'b0;
        frame_done_d = 1'b0;
        ram_en_d     = accept;
        din_d        = accept ? s_data : din_q;
        mode_d       = accept ? ((state_q == LOAD_W) ? MODE_WEIGHT : MODE_DATA) : mode_q;
        case (state_q)
            IDLE: begin
                cnt_d = 7'd0;
                if (start) state_d = skip_w ? LOAD_D : LOAD_W;
            end
            LOAD_W: begin
                if (accept) begin
                    if (cnt_q == W_LAST) begin
                        cnt_d   = 7'd0;
                        state_d = LOAD_D;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            LOAD_D: begin
                if (accept) begin
                    if (cnt_q == D_LAST) begin
                        cnt_d    = 7'd0;
                        settle_d = SETTLE_LOAD;
                        state_d  = SETTLE;
                    end else begin
                        cnt_d = cnt_q + 7'd1;
                    end
                end
            end
            // Entered alongside the final write; expiry at zero leaves
            // SETTLE_CYC full cycles after that write before capture.
            SETTLE: begin
                if (settle_q == 8'd0) begin
                    capture = 1'b1;
                    state_d = OUT;
                end else begin
                    settle_d = settle_q - 8'd1;
                end
            end
            OUT: begin
                if (handshake) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 7'd0;
            settle_q     <= 8'd0;
            ram_en_q     <= 1'b0;
            mode_q       <= 1'b0;
            din_q        <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            settle_q     <= settle_d;
            ram_en_q     <= ram_en_d;
            mode_q       <= mode_d;
            din_q        <= din_d;
            frame_done_q <= frame_done_d;
        end
    end

    seq_out_reg u_out (
        .clk      (clk),
        .rst      (rst),
        .capture  (capture),
        .cap_data (res_data),
        .cap_flag (res_flag),
        .m_ready  (m_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_flag   (m_flag)
    );

    assign ram_en     = ram_en_q;
    assign mode       = mode_q;
    assign din        = din_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_load_sequencer.sv
// Self-checking bench for load_sequencer with a frame-level reference model.
module tb_load_sequencer;

    localparam int W = 54;
    localparam int D = 64;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic [7:0] res_data = 8'h00;
    logic       res_flag = 1'b0;
    logic       m_ready = 1'b0;
`ifdef LOAD_SEQ_KEEPW_EN
    logic       keep_w = 1'b0;
`endif
    logic       s_ready, mode, ram_en, m_valid, m_flag, busy, frame_done;
    logic [7:0] din, m_data;

    load_sequencer #(.W_BYTES(W), .D_BYTES(D), .SETTLE_CYC(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef LOAD_SEQ_KEEPW_EN
        .keep_w     (keep_w),
`endif
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mode       (mode),
        .ram_en     (ram_en),
        .din        (din),
        .res_data   (res_data),
        .res_flag   (res_flag),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_flag     (m_flag),
        .m_ready    (m_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_cyc = -1;
    int nw = 0;
    int nd = 0;
    bit rand_res = 1'b1;
    bit frame_keep = 1'b0;

    // Reference model: frame-level view (bytes taken, settle countdown).
    bit         m_active = 1'b0;
    bit         m_keep = 1'b0;
    int         m_taken = 0;
    int         m_wait = 0;
    bit         e_ram_en = 1'b0;
    bit         e_mode = 1'b0;
    logic [7:0] e_din = 8'h00;
    bit         e_mv = 1'b0;
    logic [7:0] e_md = 8'h00;
    bit         e_mf = 1'b0;
    bit         e_fd = 1'b0;

    function automatic int need_bytes();
        return m_keep ? D : (W + D);
    endfunction

    function automatic bit exp_sready();
        return m_active && (m_taken < need_bytes());
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        bit was_active;
        bit acc;
        bit hs;
        if (rst) begin
            m_active = 0; m_keep = 0; m_taken = 0; m_wait = 0;
            e_ram_en = 0; e_mode = 0; e_din = 8'h00;
            e_mv = 0; e_md = 8'h00; e_mf = 0; e_fd = 0;
        end else begin
            was_active = m_active;
            acc = exp_sready() && s_valid;
            hs  = e_mv && m_ready;
            e_ram_en = acc;
            e_fd = 0;
            if (acc) begin
                e_din  = s_data;
                e_mode = !m_keep && (m_taken < W);
                m_taken++;
                if (m_taken == need_bytes()) m_wait = S + 1;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    e_mv = 1;
                    e_md = res_data;
                    e_mf = res_flag;
                end
            end
            if (hs) begin
                e_mv = 0;
                e_fd = 1;
                m_active = 0;
            end
            if (!was_active && start) begin
                m_active = 1;
                m_taken  = 0;
                m_keep   = frame_keep;
            end
        end
    endtask

    // One clock: update model, let the edge pass, compare outputs.
    task automatic tick();
        if (rand_res) begin
            res_data = 8'($urandom);
            res_flag = 1'($urandom);
        end
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        chk("s_ready", s_ready, exp_sready());
        chk("busy", busy, m_active);
        chk("ram_en", ram_en, e_ram_en);
        chk("frame_done", frame_done, e_fd);
        chk("m_valid", m_valid, e_mv);
        if (e_ram_en) begin
            chk("din", din, e_din);
            chk("mode", mode, e_mode);
        end
        if (e_mv) begin
            chk("m_data", m_data, e_md);
            chk("m_flag", m_flag, e_mf);
        end
        if (ram_en === 1'b1) begin
            if (mode === 1'b1) nw++;
            else nd++;
        end
        if (frame_done === 1'b1) done_cyc = cyc;
    endtask

    // vmode: 0 steady, 1 toggling, 2 random; rmode: 0 ready, 2 random;
    // inj: 0 none, 1 random start pulses, 2 start held high all frame.
    task automatic run_frame(input int vmode, input int rmode, input int inj, input bit kw);
        nw = 0; nd = 0; done_cyc = -1; cyc = 0;
        frame_keep = kw;
`ifdef LOAD_SEQ_KEEPW_EN
        keep_w = kw;
`endif
        m_ready = 1'b1;
        s_valid = (vmode == 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3000 && done_cyc < 0; i++) begin
            case (vmode)
                0:       s_valid = 1'b1;
                1:       s_valid = (i % 2 == 0);
                default: s_valid = 1'($urandom_range(0, 1));
            endcase
            s_data  = 8'($urandom);
            m_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            case (inj)
                1:       start = ($urandom_range(0, 7) == 0);
                2:       start = 1'b1;
                default: start = 1'b0;
            endcase
            tick();
        end
        start = 1'b0;
        s_valid = 1'b0;
        chk("frame_done_seen", (done_cyc >= 0), 1);
        chk("weight_writes", nw, kw ? 0 : W);
        chk("data_writes", nd, D);
        if (vmode == 0 && rmode == 0)
            chk("latency", done_cyc, kw ? 69 : 123);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_after_frame", busy, 0);
        end
    endtask

    task automatic hold_test();
        rand_res = 1'b0;
        res_data = 8'hA5;
        res_flag = 1'b1;
        nw = 0; nd = 0; done_cyc = -1; cyc = 0;
        frame_keep = 1'b0;
`ifdef LOAD_SEQ_KEEPW_EN
        keep_w = 1'b0;
`endif
        m_ready = 1'b0;
        s_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 400 && m_valid !== 1'b1; i++) begin
            s_data = 8'($urandom);
            tick();
        end
        chk("hold_mvalid_rose", m_valid, 1);
        s_valid = 1'b0;
        res_data = 8'h3C;
        res_flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_mvalid", m_valid, 1);
            chk("hold_mdata", m_data, 8'hA5);
            chk("hold_mflag", m_flag, 1);
            chk("hold_no_done", frame_done, 0);
        end
        m_ready = 1'b1;
        tick();
        chk("hold_done_pulse", frame_done, 1);
        tick();
        chk("hold_done_single", frame_done, 0);
        chk("hold_counts", nw * 1000 + nd, W * 1000 + D);
        rand_res = 1'b1;
    endtask

    task automatic abort_test();
        nw = 0; nd = 0; cyc = 0;
        frame_keep = 1'b0;
`ifdef LOAD_SEQ_KEEPW_EN
        keep_w = 1'b0;
`endif
        m_ready = 1'b1;
        s_valid = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && nw < 30; i++) begin
            s_data = 8'($urandom);
            tick();
        end
        chk("abort_30_written", nw, 30);
        rst = 1'b1;
        tick();
        chk("abort_ram_en", ram_en, 0);
        chk("abort_s_ready", s_ready, 0);
        chk("abort_busy", busy, 0);
        rst = 1'b0;
        s_valid = 1'b0;
        tick();
        run_frame(0, 0, 0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_mode", mode, 0);
        chk("rst_din", din, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_flag", m_flag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        tick();

        run_frame(0, 0, 0, 1'b0);   // back-to-back stream
        run_frame(1, 0, 0, 1'b0);   // s_valid toggling
        hold_test();
        abort_test();
        run_frame(0, 0, 2, 1'b0);   // start held through LOAD_D, OUT and handshake
        run_frame(2, 2, 2, 1'b0);
        for (int k = 0; k < 3; k++) run_frame(2, 2, 1, 1'b0);
`ifdef LOAD_SEQ_KEEPW_EN
        run_frame(0, 0, 0, 1'b1);
        run_frame(2, 2, 1, 1'b1);
        run_frame(0, 0, 0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
